// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants and types for the write-back arbiter
//
// Package rf_pkg
//   ADDR_W, DATA_W : default register index / write data widths
//   N_REQ_DEFAULT  : default number of write-back requesters
//   rf_idx_t       : register index type
//   rf_wb_t        : one pending register-file write {rd, data}
package rf_pkg;

  localparam int ADDR_W        = 5;
  localparam int DATA_W        = 32;
  localparam int N_REQ_DEFAULT = 3;

  typedef logic [ADDR_W-1:0] rf_idx_t;

  typedef struct packed {
    rf_idx_t           rd;
    logic [DATA_W-1:0] data;
  } rf_wb_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - requester and register-file write port bundle
//
// Interface regfile_wb_arbiter_if #(N_REQ, DATA_W, ADDR_W)
//   req_valid  [N_REQ]         : requester i has a write pending
//   req_ready  [N_REQ]         : requester i accepted this cycle
//   req_rd     [N_REQ*ADDR_W]  : destination register, slice i*ADDR_W +: ADDR_W
//   req_data   [N_REQ*DATA_W]  : write data, slice i*DATA_W +: DATA_W
//   stall                      : freeze the output stage
//   rf_write_enable/rf_rd/rf_data : register file write port
//   pend_valid/pend_rd         : uncommitted write, for hazard logic
// Modports: master (requesters + pipeline control), slave (the arbiter).
interface regfile_wb_arbiter_if #(
  parameter int N_REQ  = rf_pkg::N_REQ_DEFAULT,
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_rd;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    stall;
  logic                    rf_write_enable;
  logic [ADDR_W-1:0]       rf_rd;
  logic [DATA_W-1:0]       rf_data;
  logic                    pend_valid;
  logic [ADDR_W-1:0]       pend_rd;

  modport master (
    output req_valid, req_rd, req_data, stall,
    input  req_ready, rf_write_enable, rf_rd, rf_data, pend_valid, pend_rd
  );

  modport slave (
    input  req_valid, req_rd, req_data, stall,
    output req_ready, rf_write_enable, rf_rd, rf_data, pend_valid, pend_rd
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - combinational one-hot grant selection
//
// Module rr_arbiter #(N)
//   req [N]  : request vector
//   ptr [IW] : index of the last winner; search starts at ptr+1
//   en       : when low no grant is issued
//   gnt [N]  : one-hot grant (all zero if nothing granted)
// Macro REGFILE_WB_RR_EN: defined -> round-robin, undefined -> lowest index wins
// (ptr is ignored in the fixed-priority build).
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

`ifdef REGFILE_WB_RR_EN
  // Walk the requesters starting just after the last winner, wrapping at N.
  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Isolate the lowest set bit.
  assign gnt = en ? (req & (~req + N'(1))) : '0;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port among write-back requesters
//
// Module regfile_wb_arbiter #(N_REQ, DATA_W, ADDR_W)
//   clk  : clock
//   rst  : synchronous, active-low reset
//   bus  : regfile_wb_arbiter_if.slave (requester handshakes, stall,
//          register-file write port, pending-write hazard outputs)
// Macro REGFILE_WB_RR_EN: defined -> round-robin arbitration with a pointer
// register; undefined -> fixed priority (lowest index), no pointer register.
//
// One grant per cycle is latched into a single-entry output stage that drives
// the register file on the following cycle. Writes to x0 occupy the stage but
// never assert write_enable or pend_valid.
module regfile_wb_arbiter #(
  parameter int N_REQ  = rf_pkg::N_REQ_DEFAULT,
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  import rf_pkg::*;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  rf_wb_t            entry_q;
  logic              full_q;
  // High for the single cycle after a reset edge; blocks grants so that all
  // outputs stay zero through that cycle.
  logic              blank_q;

  logic [N_REQ-1:0]  gnt;
  logic [IW-1:0]     ptr;
  logic              grant;
  logic              accept;
  logic              arb_en;
  logic              drain;
  logic              entry_x0;
  rf_idx_t           win_rd;
  logic [DATA_W-1:0] win_data;

  assign accept   = ~full_q | ~bus.stall;
  assign arb_en   = rst & ~blank_q & accept;
  assign drain    = full_q & ~bus.stall;
  assign grant    = |gnt;
  assign entry_x0 = (entry_q.rd == '0);

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (gnt)
  );

  // Winner's rd/data; gnt is one-hot so a plain priority mux suffices.
  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_rd   = bus.req_rd[i*ADDR_W +: ADDR_W];
        win_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef REGFILE_WB_RR_EN
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] ptr_q;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = IW'(i);
      end
    end
  end

  // Reset to N_REQ-1 so requester 0 is first in line; moves only on a grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= IW'(N_REQ - 1);
    end else if (grant) begin
      ptr_q <= gnt_idx;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Output stage. A grant always wins over a drain: when both happen the old
  // entry is written this cycle and the new one replaces it at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q  <= 1'b0;
      entry_q <= '0;
      blank_q <= 1'b1;
    end else begin
      blank_q <= 1'b0;
      if (grant) begin
        full_q       <= 1'b1;
        entry_q.rd   <= win_rd;
        entry_q.data <= win_data;
      end else if (drain) begin
        full_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = gnt;

  // Gating with rst discards a pending entry during the reset cycle rather
  // than letting it reach the register file.
  assign bus.rf_write_enable = rst & drain & ~entry_x0;
  assign bus.rf_rd           = rst ? entry_q.rd   : '0;
  assign bus.rf_data         = rst ? entry_q.data : '0;
  assign bus.pend_valid      = rst & full_q & ~entry_x0;
  assign bus.pend_rd         = rst ? entry_q.rd   : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard testbench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  import rf_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N-1:0]  ready;
    logic          we;
    logic          pv;
    logic [AW-1:0] prd;
  } cyc_t;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  cyc_t cyc_q[$];
  wr_t  wq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one-slot write buffer plus last-winner index.
  bit            m_full  = 1'b0;
  bit            m_blank = 1'b0;
  logic [AW-1:0] m_rd    = '0;
  logic [DW-1:0] m_data  = '0;
  int            m_last  = N - 1;

  logic [N-1:0] hs;
  bit           refill = 1'b0;
  bit           rnd    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    int w;
    w = -1;
`ifdef REGFILE_WB_RR_EN
    for (int k = 1; k <= N; k++) begin
      if (w < 0 && v[(last + k) % N]) w = (last + k) % N;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) w = i;
    end
`endif
    return w;
  endfunction

  // Predictor: computes this cycle's expected outputs and the next model state.
  always @(negedge clk) begin
    cyc_t e;
    int   w;
    e.ready = '0;
    e.we    = 1'b0;
    e.pv    = 1'b0;
    e.prd   = '0;
    if (!rst) begin
      m_full  = 1'b0;
      m_blank = 1'b1;
      m_last  = N - 1;
      wq.delete();
    end else begin
      e.we  = m_full && !bus.stall && (m_rd != 0);
      e.pv  = m_full && (m_rd != 0);
      e.prd = m_rd;
      w = -1;
      if (!m_blank && (!m_full || !bus.stall)) w = pick(bus.req_valid, m_last);
      if (w >= 0) begin
        e.ready[w] = 1'b1;
        m_full = 1'b1;
        m_rd   = bus.req_rd[w*AW +: AW];
        m_data = bus.req_data[w*DW +: DW];
        m_last = w;
        if (m_rd != 0) wq.push_back('{m_rd, m_data});
      end else if (m_full && !bus.stall) begin
        m_full = 1'b0;
      end
      m_blank = 1'b0;
    end
    cyc_q.push_back(e);
  end

  // Monitor: compares DUT outputs against the queued expectations.
  always @(negedge clk) begin
    cyc_t e;
    wr_t  x;
    #1;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("req_ready", 64'(bus.req_ready), 64'(e.ready));
      chk("rf_write_enable", 64'(bus.rf_write_enable), 64'(e.we));
      chk("pend_valid", 64'(bus.pend_valid), 64'(e.pv));
      if (e.pv) chk("pend_rd", 64'(bus.pend_rd), 64'(e.prd));
    end
    if (bus.rf_write_enable === 1'b1) begin
      chk("write_expected", 64'(wq.size() > 0), 64'd1);
      if (wq.size() > 0) begin
        x = wq.pop_front();
        chk("rf_rd", 64'(bus.rf_rd), 64'(x.rd));
        chk("rf_data", 64'(bus.rf_data), 64'(x.data));
      end
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.req_valid[i]            = 1'b1;
    bus.req_rd[i*AW +: AW]      = rd;
    bus.req_data[i*DW +: DW]    = d;
  endtask

  // One clock: note handshakes, retire accepted requests, issue new ones.
  task automatic cycle();
    @(negedge clk);
    hs = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) bus.req_valid[i] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (!bus.req_valid[i]) begin
        if (refill) set_req(i, AW'(i + 1), DW'(i));
        else if (rnd && $urandom_range(1, 0) == 1)
          set_req(i, AW'($urandom_range(7, 0)), $urandom);
      end
    end
    if (rnd) bus.stall = ($urandom_range(3, 0) == 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && bus.req_valid != '0; k++) cycle();
    repeat (3) cycle();
    chk("drain_done", 64'(bus.req_valid), 64'd0);
  endtask

  initial begin
    rst           = 1'b0;
    bus.stall     = 1'b0;
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;

    // Reset held with every requester valid.
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), DW'(i));
    repeat (3) cycle();
    rst = 1'b1;

    // Continuous contention.
    refill = 1'b1;
    repeat (12) cycle();
    refill = 1'b0;
    drain();

    // Single write.
    set_req(1, 5'd7, 32'hDEADBEEF);
    repeat (3) cycle();

    // Stall with a held entry and a waiting requester.
    set_req(0, 5'd3, 32'h33);
    cycle();
    bus.stall = 1'b1;
    set_req(2, 5'd12, 32'h22);
    repeat (4) cycle();
    bus.stall = 1'b0;
    repeat (3) cycle();

    // Write to x0.
    set_req(0, 5'd0, 32'h55);
    repeat (3) cycle();

    // Reset while the entry holds rd=9, with another request waiting.
    set_req(1, 5'd9, 32'h99);
    cycle();
    rst = 1'b0;
    set_req(2, 5'd4, 32'h44);
    cycle();
    rst = 1'b1;
    repeat (4) cycle();

    // Randomised traffic and stalls.
    rnd = 1'b1;
    repeat (400) cycle();
    rnd       = 1'b0;
    bus.stall = 1'b0;
    drain();

    chk("writes_outstanding", 64'(wq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port among `N_REQ` write-back requesters, such as the ALU, load unit and multiplier. Each requester uses a valid/ready handshake. Each cycle the block grants one requester and latches its `{rd, data}` into a one-entry output stage. That stage drives the register file's `write_enable`/`rd1`/`data_in` pins. The block sits between the execute/memory units and the register file, and is the only agent allowed to drive the write port.

## Interface
Parameters:
- `N_REQ`, default 3: number of write-back requesters (2..8).
- `DATA_W`, default 32: write data width.
- `ADDR_W`, default 5: register index width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `req_valid` in `N_REQ`: requester i has a write pending.
- `req_ready` out `N_REQ`: requester i is accepted this cycle. The handshake completes when `req_valid[i] & req_ready[i]`.
- `req_rd` in `N_REQ*ADDR_W`: destination register per requester; requester i occupies slice `[i*ADDR_W +: ADDR_W]`.
- `req_data` in `N_REQ*DATA_W`: write data per requester, sliced the same way.
- `stall` in 1: freeze the output stage; no register-file write occurs this cycle.
- `rf_write_enable` out 1: to register file `write_enable`.
- `rf_rd` out `ADDR_W`: to register file `rd1`.
- `rf_data` out `DATA_W`: to register file `data_in`.
- `pend_valid` out 1: output stage holds a write that is not yet committed. Used by hazard logic.
- `pend_rd` out `ADDR_W`: destination register of the pending write.

## Operation
- **Output stage.** One entry, `{full, rd, data}`.
  - `rf_write_enable = full & ~stall`. `rf_rd` and `rf_data` come from the entry.
  - `pend_valid = full`; `pend_rd` = entry rd.
- **Drain.** The entry drains on any cycle where `full & ~stall`.
- **Can-accept condition.** `accept = ~full | ~stall`.
  - If `accept` is 0, all `req_ready` bits are 0.
  - Otherwise exactly one `req_ready` bit, belonging to the arbitration winner among the valid requesters, is 1.
  - If no requester is valid, all `req_ready` bits are 0.
- **`req_ready` generation.** `req_ready` is combinational from `req_valid`, `full`, `stall` and the pointer. It never depends on `req_ready` itself.
- **Entry update on a grant.** The entry loads the winner's rd/data and `full` becomes 1.
- **Entry update with no grant.** If the entry drains and nothing is granted, `full` becomes 0.
- **Writes to x0.** A request with `rd == 0` is accepted normally and occupies the entry, but its output is suppressed:
  - `rf_write_enable` is forced to 0 for that entry;
  - `pend_valid` stays 0 for it.
- **Same rd, same cycle.** Two requesters targeting the same rd in one cycle are serialised. The later-granted value is the final register content.
- **Arbitration.** Round-robin or fixed priority, selected by the Configuration section.
- **Reset.** While `rst` = 0 at a clock edge:
  - `full` ← 0, `rd` ← 0, `data` ← 0;
  - the round-robin pointer ← `N_REQ-1`, so requester 0 has first priority.
  - All outputs read 0 during the reset cycle and the cycle after.
  - A pending entry is discarded, not written. This is consistent with the register file clearing itself on the same edge.

## Timing
- **Acceptance to write.** A request accepted in cycle t drives `rf_write_enable` in cycle t+1, unless stalled. The register file captures it at the end of t+1, and the value is readable in cycle t+2.
- **Throughput.** One write per cycle with back-to-back grants and no bubble while `stall` = 0.
- **Stall.** `stall` high holds the entry, with outputs stable and `write_enable` low.
  - A new grant is allowed only if the entry is empty.
  - At most one request is buffered during a stall.
- **Requester obligations.** Requesters hold `req_valid`, `req_rd` and `req_data` stable until accepted. The arbiter must not drop or duplicate a request.

## Configuration
- `REGFILE_WB_RR_EN` defined: round-robin.
  - Priority starts at `(ptr+1) mod N_REQ` and wraps.
  - `ptr` ← granted index on each grant only; it is unchanged in cycles with no grant.
- `REGFILE_WB_RR_EN` undefined: fixed priority.
  - The lowest index wins.
  - No pointer register is instantiated.

## Structure
- **Package `rf_pkg`.**
  - `ADDR_W` = 5 and `DATA_W` = 32 constants.
  - `N_REQ_DEFAULT` = 3.
  - Typedef `rf_idx_t` (`logic [ADDR_W-1:0]`).
  - Typedef `rf_wb_t`: struct `{rd, data}` used for the output-stage entry.
- **Sub-module `rr_arbiter`.**
  - Parameter `N`.
  - Inputs: `req`, `ptr`, `en`.
  - Output: one-hot `gnt`.
  - Purely combinational grant selection.
  - It contains both the round-robin and fixed-priority variants under the macro.

## Test plan
- **Reset.** Hold `rst`=0 for 3 cycles with all `req_valid`=1 → `req_ready`=0 and `rf_write_enable`=0 throughout. After release, the first grant goes to requester 0.
- **Single write.** Requester 1 asserts rd=7, data=0xDEADBEEF at t → `req_ready[1]`=1 at t; `rf_write_enable`=1, `rf_rd`=7, `rf_data`=0xDEADBEEF at t+1; `pend_valid`=0 at t+2.
- **Continuous contention.** All 3 requesters hold valid continuously, with requester i writing data=i.
  - With `REGFILE_WB_RR_EN` defined: grant order is 0,1,2,0,1,2…, one write per cycle.
  - Without it: requester 0 wins every cycle.
- **Stall.** Entry holds rd=3 and `stall`=1 for 4 cycles while requester 2 is valid.
  - `rf_write_enable`=0 and `req_ready`=0 throughout.
  - On `stall`=0, rd=3 is written and requester 2 is granted the same cycle.
  - Requester 2's write appears the next cycle.
- **x0 write.** Requester 0 writes rd=0, data=0x55 → accepted, `rf_write_enable` stays 0, `pend_valid`=0.
- **Reset mid-operation.** `rst`=0 while the entry is full with rd=9 → no write to rd=9 occurs, and `full`=0 after the edge.
